// File: rtl/sys_defs.sv
// sys_defs: shared memory-bus types and default sizing for the MEM_IN/MEM_OUT interface
package sys_defs;
    localparam int NUM_MEM_TAGS = 15;
    localparam int MEM_LATENCY_IN_CYCLES = 4;
    localparam int TAG_W = $clog2(NUM_MEM_TAGS + 1);
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;
    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        MEM_SIZE     size;
        BUS_COMMAND  command;
    } MEM_IN;
    typedef struct packed {
        logic [TAG_W-1:0] response;
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } MEM_OUT;
endpackage

// File: rtl/mem_tag_alloc.sv
// mem_tag_alloc: free-tag bitmap handing out the lowest free tag (1..N), with registered busy count
module mem_tag_alloc #(
    parameter int N = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_i,
    input  logic                   free_i,
    input  logic [$clog2(N+1)-1:0] free_tag_i,
    output logic [$clog2(N+1)-1:0] tag_o,
    output logic                   full_o,
    output logic [$clog2(N+1)-1:0] busy_cnt_o
);
    localparam int W = $clog2(N + 1);
    logic [N-1:0] r_busy, w_busy;
    logic [W-1:0] r_cnt, w_cnt;
    always_comb begin
        tag_o = '0;
        w_busy = r_busy;
        w_cnt = '0;
        for (int i = N - 1; i >= 0; i--) tag_o = r_busy[i] ? tag_o : W'(i + 1);
        for (int i = 0; i < N; i++) begin
            w_busy[i] = (alloc_i && tag_o == W'(i + 1)) || (r_busy[i] && !(free_i && free_tag_i == W'(i + 1)));
            w_cnt = w_cnt + W'(w_busy[i]);
        end
    end
    assign full_o = &r_busy;
    assign busy_cnt_o = r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
            r_cnt <= '0;
        end else begin
            r_busy <= w_busy;
            r_cnt <= w_cnt;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: tagged fixed-latency memory target; loads read at accept and return MEM_LAT cycles later
module mem_responder
    import sys_defs::*;
#(
    parameter int MEM_LAT   = MEM_LATENCY_IN_CYCLES,
    parameter int TAG_NUM   = NUM_MEM_TAGS,
    parameter int MEM_DEPTH = 8192
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  MEM_IN                        proc2mem_i,
    output MEM_OUT                       mem2proc_o,
    output logic [$clog2(TAG_NUM+1)-1:0] busy_cnt_o
);
    localparam int TW = $clog2(TAG_NUM + 1);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int AW = $clog2(MEM_DEPTH);
    logic [63:0] unified_memory [MEM_DEPTH];
    logic [CW-1:0] r_cnt [TAG_NUM];
    logic [63:0] r_buf [TAG_NUM];
    logic [TAG_W-1:0] r_ret_tag, w_ret_tag, w_resp;
    logic [63:0] r_ret_data, w_ret_data, w_rd_word;
    logic [TW-1:0] w_tag;
    logic w_full, w_oob, w_load_acc, w_store_acc;
    logic [AW-1:0] w_idx;
    logic [7:0] w_mask;
    function automatic logic [7:0] lane_mask(input MEM_SIZE s, input logic [2:0] a);
        return s == BYTE ? 8'h01 << a :
               s == HALF ? 8'h03 << {a[2:1], 1'b0} :
               s == WORD ? 8'h0F << {a[2], 2'b00} : 8'hFF;
    endfunction
    assign w_oob = {3'b000, proc2mem_i.addr[31:3]} >= 32'(MEM_DEPTH);
    assign w_idx = proc2mem_i.addr[AW+2:3];
    assign w_rd_word = unified_memory[w_idx];
    assign w_mask = lane_mask(proc2mem_i.size, proc2mem_i.addr[2:0]);
    assign w_load_acc = !rst_i && proc2mem_i.command == BUS_LOAD && !w_oob && !w_full;
    assign w_store_acc = !rst_i && proc2mem_i.command == BUS_STORE && !w_oob;
    assign w_resp = w_load_acc ? TAG_W'(w_tag) : w_store_acc ? TAG_W'(1) : '0;
    assign mem2proc_o = '{response: w_resp, data: r_ret_data, tag: r_ret_tag};
    mem_tag_alloc #(.N(TAG_NUM)) u_alloc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alloc_i    (w_load_acc),
        .free_i     (r_ret_tag != '0),
        .free_tag_i (TW'(r_ret_tag)),
        .tag_o      (w_tag),
        .full_o     (w_full),
        .busy_cnt_o (busy_cnt_o)
    );
    // With MEM_LAT=1 the returning word is the one being captured this very edge.
    always_comb begin
        w_ret_tag = '0;
        w_ret_data = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            if ((w_load_acc && w_tag == TW'(i + 1)) ? MEM_LAT == 1 : int'(r_cnt[i]) == 2) begin
                w_ret_tag = TAG_W'(i + 1);
                w_ret_data = (w_load_acc && w_tag == TW'(i + 1)) ? w_rd_word : r_buf[i];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAG_NUM; i++) r_cnt[i] <= '0;
            r_ret_tag <= '0;
            r_ret_data <= '0;
        end else begin
            for (int i = 0; i < TAG_NUM; i++)
                r_cnt[i] <= (w_load_acc && w_tag == TW'(i + 1)) ? CW'(MEM_LAT) : r_cnt[i] - CW'(r_cnt[i] != '0);
            r_ret_tag <= w_ret_tag;
            r_ret_data <= w_ret_data;
        end
    end
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < TAG_NUM; i++)
            if (w_load_acc && w_tag == TW'(i + 1)) r_buf[i] <= w_rd_word;
        if (w_store_acc)
            for (int b = 0; b < 8; b++)
                if (w_mask[b]) unified_memory[w_idx][8*b +: 8] <= proc2mem_i.data[8*b +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a cycle-indexed reference model
module tb_mem_responder;
    import sys_defs::*;
    localparam int LAT = 16;
    localparam int NT = 15;
    localparam int DEPTH = 8192;
    logic clk = 1'b0;
    logic rst = 1'b1;
    MEM_IN p2m;
    MEM_OUT m2p;
    logic [3:0] busy;
    always #5 clk = ~clk;
    mem_responder #(.MEM_LAT(LAT), .TAG_NUM(NT), .MEM_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .proc2mem_i (p2m),
        .mem2proc_o (m2p),
        .busy_cnt_o (busy)
    );
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc [16];
    logic [63:0] tag_data [16];
    logic [63:0] mdl [DEPTH];
    logic [3:0] e_resp, e_tag, e_busy;
    logic [63:0] e_data;
    // a tag accepted in cycle a is busy in cycles a+1 .. a+LAT and returns in a+LAT
    function automatic bit is_busy(input int t, input int c);
        return acc_cyc[t] < c && c <= acc_cyc[t] + LAT;
    endfunction
    task automatic drive(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] data, input MEM_SIZE sz);
        int w, nb, base, cnt;
        w = int'(addr >> 3);
        p2m.addr = addr;
        p2m.data = data;
        p2m.size = sz;
        p2m.command = cmd;
        cnt = 0;
        e_tag = '0;
        e_data = '0;
        e_resp = '0;
        for (int t = 1; t <= NT; t++) begin
            cnt += int'(is_busy(t, cyc));
            if (acc_cyc[t] + LAT == cyc) begin
                e_tag = 4'(t);
                e_data = tag_data[t];
            end
        end
        e_busy = 4'(cnt);
        if (!rst && cmd == BUS_LOAD && w < DEPTH) begin
            for (int t = NT; t >= 1; t--) if (!is_busy(t, cyc)) e_resp = 4'(t);
            if (e_resp != 0) begin
                acc_cyc[e_resp] = cyc;
                tag_data[e_resp] = mdl[w];
            end
        end
        if (!rst && cmd == BUS_STORE && w < DEPTH) begin
            e_resp = 4'd1;
            nb = 1 << int'(sz);
            base = int'(addr[2:0]) / nb * nb;
            for (int b = 0; b < 8; b++) if (b >= base && b < base + nb) mdl[w][8*b +: 8] = data[8*b +: 8];
        end
        #2;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic reset_dut(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            tick();
            for (int t = 0; t <= NT; t++) acc_cyc[t] = -1000;
        end
        rst = 1'b0;
    endtask
    task automatic test_reset();
        drive(BUS_LOAD, 0, 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd0) begin n_err++; $display("FAIL reset_resp got=%0d want=0", m2p.response); end
        tick();
        reset_dut(1);
        drive(BUS_NONE, 0, 0, BYTE);
        n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL reset_busy got=%0d want=0", busy); end
        n_cmp++; if (m2p.tag !== 4'd0) begin n_err++; $display("FAIL reset_tag got=%0d want=0", m2p.tag); end
        n_cmp++; if (m2p.data !== 64'd0) begin n_err++; $display("FAIL reset_data got=%h want=0", m2p.data); end
        for (int w = 0; w < 16; w++) begin
            drive(BUS_STORE, 32'(w * 8), {$urandom, $urandom}, DOUBLE);
            tick();
        end
    endtask
    task automatic test_single_load();
        drive(BUS_STORE, 0, 64'h1111_2222_3333_4444, DOUBLE);
        tick();
        reset_dut(2);
        drive(BUS_LOAD, 0, 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd1) begin n_err++; $display("FAIL single_resp got=%0d want=1", m2p.response); end
        tick();
        for (int k = 1; k <= LAT + 1; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== (k == LAT ? 4'd1 : 4'd0)) begin n_err++; $display("FAIL single_tag k=%0d got=%0d", k, m2p.tag); end
            n_cmp++; if (m2p.data !== (k == LAT ? 64'h1111_2222_3333_4444 : 64'd0)) begin n_err++; $display("FAIL single_data k=%0d got=%h", k, m2p.data); end
            tick();
        end
    endtask
    task automatic test_tag_exhaust();
        int s, got;
        s = cyc;
        got = -1;
        for (int i = 1; i <= NT; i++) begin
            drive(BUS_LOAD, 32'($urandom_range(0, 15) * 8), 0, DOUBLE);
            n_cmp++; if (m2p.response !== 4'(i)) begin n_err++; $display("FAIL exhaust_resp i=%0d got=%0d want=%0d", i, m2p.response, i); end
            tick();
        end
        drive(BUS_LOAD, 8, 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd0) begin n_err++; $display("FAIL exhaust_full_resp got=%0d want=0", m2p.response); end
        n_cmp++; if (busy !== 4'd15) begin n_err++; $display("FAIL exhaust_busy got=%0d want=15", busy); end
        tick();
        for (int k = 0; k < 8 && got < 0; k++) begin
            drive(BUS_LOAD, 8, 0, DOUBLE);
            if (m2p.response !== 4'd0) got = cyc;
            tick();
        end
        n_cmp++; if (got != s + LAT + 1) begin n_err++; $display("FAIL exhaust_reaccept_cycle got=%0d want=%0d", got - s, LAT + 1); end
        n_cmp++; if (acc_cyc[1] != got) begin n_err++; $display("FAIL exhaust_reaccept_tag model tag1 accept=%0d dut accept=%0d", acc_cyc[1] - s, got - s); end
        for (int k = 0; k < 2 * LAT; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== e_tag || m2p.data !== e_data) begin n_err++; $display("FAIL exhaust_drain tag=%0d data=%h want tag=%0d data=%h", m2p.tag, m2p.data, e_tag, e_data); end
            tick();
        end
    endtask
    task automatic test_store_load();
        logic [3:0] tg;
        bit found;
        found = 0;
        drive(BUS_STORE, 16, 64'd0, DOUBLE);
        tick();
        drive(BUS_STORE, 19, 64'hFFFF_FFFF_AB00_0000, BYTE);
        n_cmp++; if (m2p.response !== 4'd1) begin n_err++; $display("FAIL store_resp got=%0d want=1", m2p.response); end
        tick();
        drive(BUS_LOAD, 16, 0, DOUBLE);
        tg = e_resp;
        n_cmp++; if (m2p.response !== tg || tg == 0) begin n_err++; $display("FAIL store_load_resp got=%0d want=%0d", m2p.response, tg); end
        tick();
        for (int k = 0; k < LAT + 1; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            if (m2p.tag === tg && tg != 0) begin
                found = 1;
                n_cmp++; if (m2p.data !== 64'h0000_0000_AB00_0000) begin n_err++; $display("FAIL store_load_data got=%h want=00000000ab000000", m2p.data); end
            end
            tick();
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL store_load_timeout got=no_return want=tag%0d", tg); end
    endtask
    task automatic test_out_of_range();
        drive(BUS_LOAD, 32'(DEPTH * 8), 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd0) begin n_err++; $display("FAIL oor_load_resp got=%0d want=0", m2p.response); end
        tick();
        drive(BUS_STORE, 32'(DEPTH * 8), 64'hDEAD_DEAD_DEAD_DEAD, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd0) begin n_err++; $display("FAIL oor_store_resp got=%0d want=0", m2p.response); end
        n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL oor_busy got=%0d want=0", busy); end
        tick();
        drive(BUS_STORE, 32'((DEPTH - 1) * 8 + 4), 64'h5A5A_5A5A_0000_0000, WORD);
        n_cmp++; if (m2p.response !== 4'd1) begin n_err++; $display("FAIL last_store_resp got=%0d want=1", m2p.response); end
        tick();
        drive(BUS_STORE, 32'((DEPTH - 1) * 8), 64'h0000_0000_1234_5678, WORD);
        tick();
        drive(BUS_LOAD, 32'((DEPTH - 1) * 8), 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd1) begin n_err++; $display("FAIL last_load_resp got=%0d want=1", m2p.response); end
        tick();
        drive(BUS_LOAD, 0, 0, DOUBLE);
        tick();
        for (int k = 0; k < LAT + 2; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== e_tag || m2p.data !== e_data || busy !== e_busy) begin n_err++; $display("FAIL oor_drain tag=%0d data=%h busy=%0d want tag=%0d data=%h busy=%0d", m2p.tag, m2p.data, busy, e_tag, e_data, e_busy); end
            tick();
        end
    endtask
    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            drive(BUS_LOAD, 32'(i * 8), 0, DOUBLE);
            tick();
        end
        reset_dut(1);
        for (int k = 0; k < LAT + 2; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== 4'd0 || busy !== 4'd0) begin n_err++; $display("FAIL midreset_idle k=%0d tag=%0d busy=%0d want 0/0", k, m2p.tag, busy); end
            tick();
        end
        drive(BUS_LOAD, 40, 0, DOUBLE);
        n_cmp++; if (m2p.response !== 4'd1) begin n_err++; $display("FAIL midreset_newtag got=%0d want=1", m2p.response); end
        tick();
        for (int k = 0; k < LAT + 1; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== e_tag || m2p.data !== e_data) begin n_err++; $display("FAIL midreset_drain tag=%0d data=%h want tag=%0d data=%h", m2p.tag, m2p.data, e_tag, e_data); end
            tick();
        end
    endtask
    task automatic test_accept_with_return();
        logic [3:0] ta, b;
        drive(BUS_LOAD, 8, 0, DOUBLE);
        ta = e_resp;
        tick();
        for (int k = 1; k < LAT; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            tick();
        end
        drive(BUS_LOAD, 24, 0, DOUBLE);
        b = busy;
        n_cmp++; if (m2p.tag !== ta || m2p.data !== e_data) begin n_err++; $display("FAIL overlap_return tag=%0d data=%h want tag=%0d data=%h", m2p.tag, m2p.data, ta, e_data); end
        n_cmp++; if (m2p.response !== e_resp || e_resp == ta) begin n_err++; $display("FAIL overlap_accept got=%0d want=%0d", m2p.response, e_resp); end
        tick();
        drive(BUS_NONE, 0, 0, BYTE);
        n_cmp++; if (busy !== b) begin n_err++; $display("FAIL overlap_busy got=%0d want=%0d", busy, b); end
        tick();
        for (int k = 0; k < LAT; k++) begin
            drive(BUS_NONE, 0, 0, BYTE);
            n_cmp++; if (m2p.tag !== e_tag || m2p.data !== e_data) begin n_err++; $display("FAIL overlap_drain tag=%0d data=%h want tag=%0d data=%h", m2p.tag, m2p.data, e_tag, e_data); end
            tick();
        end
    endtask
    task automatic test_random();
        int r;
        logic [31:0] a;
        for (int k = 0; k < 600 + 2 * LAT; k++) begin
            r = (k < 600) ? int'($urandom_range(0, 7)) : 0;
            a = ($urandom_range(0, 19) == 0) ? 32'(DEPTH * 8 + $urandom_range(0, 63)) : 32'($urandom_range(0, 127));
            drive(r < 3 ? BUS_NONE : r < 6 ? BUS_LOAD : BUS_STORE, a, {$urandom, $urandom}, MEM_SIZE'($urandom_range(0, 3)));
            n_cmp++; if (m2p.response !== e_resp) begin n_err++; $display("FAIL rand_resp k=%0d got=%0d want=%0d", k, m2p.response, e_resp); end
            n_cmp++; if (m2p.tag !== e_tag || m2p.data !== e_data) begin n_err++; $display("FAIL rand_return k=%0d tag=%0d data=%h want tag=%0d data=%h", k, m2p.tag, m2p.data, e_tag, e_data); end
            n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL rand_busy k=%0d got=%0d want=%0d", k, busy, e_busy); end
            tick();
        end
    endtask
    initial begin
        p2m = '0;
        for (int t = 0; t <= NT; t++) acc_cyc[t] = -1000;
        test_reset();
        test_single_load();
        test_tag_exhaust();
        test_store_load();
        test_out_of_range();
        test_reset_midflight();
        test_accept_with_return();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
